// File: rtl/puf_response_collector_if.sv
// rtl/puf_response_collector_if.sv - arbiter and consumer signal bundle for puf_response_collector
// slave  : collector view (inputs start, done_in, winner_in, ack; outputs round_clr, round_idx, busy, response, ready, timeout_err)
// master : arbiter/consumer view (directions reversed)
interface puf_response_collector_if #(
    parameter int ROUNDS = 8
);
    localparam int IW = $clog2(ROUNDS);

    logic              start;
    logic              done_in;
    logic              winner_in;
    logic              ack;
    logic              round_clr;
    logic [IW-1:0]     round_idx;
    logic              busy;
    logic [ROUNDS-1:0] response;
    logic              ready;
    logic              timeout_err;

    modport slave (
        input  start, done_in, winner_in, ack,
        output round_clr, round_idx, busy, response, ready, timeout_err
    );

    modport master (
        output start, done_in, winner_in, ack,
        input  round_clr, round_idx, busy, response, ready, timeout_err
    );
endinterface

// File: rtl/puf_response_collector.sv
// rtl/puf_response_collector.sv - sequences ROUNDS arbiter races and collects the winners into a response word
// clk : single clock, rising edge
// rst : asynchronous active-low reset
// bus : puf_response_collector_if.slave (start/ack consumer handshake, round_clr/done_in/winner_in arbiter side)
// Optional feature macro: PUF_TIMEOUT_EN (per-round wait limit of TIMEOUT cycles, sticky timeout_err)
module puf_response_collector #(
    parameter int ROUNDS     = 8,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 1023
) (
    input logic                     clk,
    input logic                     rst,
    puf_response_collector_if.slave bus
);
    localparam int IW = $clog2(ROUNDS);
    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(ROUNDS - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

    if (ROUNDS < 2 || ROUNDS > 16 || CLR_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("puf_response_collector: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_WAIT, S_HOLD} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [ROUNDS-1:0] cap_q, cap_d;
    logic [ROUNDS-1:0] resp_q, resp_d;
    logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
    logic              round_end;
    logic              round_bit;
    logic              start_word;

`ifdef PUF_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          err_q, err_d;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cap_q     <= '0;
            resp_q    <= '0;
            clr_cnt_q <= '0;
`ifdef PUF_TIMEOUT_EN
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cap_q     <= cap_d;
            resp_q    <= resp_d;
            clr_cnt_q <= clr_cnt_d;
`ifdef PUF_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cap_d      = cap_q;
        resp_d     = resp_q;
        clr_cnt_d  = clr_cnt_q;
        round_end  = 1'b0;
        round_bit  = 1'b0;
        start_word = 1'b0;
`ifdef PUF_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: start_word = bus.start;
            S_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = S_WAIT;
`ifdef PUF_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.done_in) begin
                    round_end = 1'b1;
                    round_bit = bus.winner_in;
                end
`ifdef PUF_TIMEOUT_EN
                // A real done on the expiry cycle takes priority over the timeout
                else if (to_cnt_q == TO_LAST) begin
                    round_end = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
                if (round_end) begin
                    cap_d[idx_q] = round_bit;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_HOLD;
                        resp_d  = cap_d;
                    end else begin
                        state_d   = S_CLEAR;
                        idx_d     = idx_q + 1'b1;
                        clr_cnt_d = '0;
                    end
                end
            end
            S_HOLD: begin
                if (bus.ack) begin
                    state_d    = S_IDLE;
                    start_word = bus.start;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // New word from IDLE, or straight out of HOLD when ack and start coincide;
        // response keeps the previous word until this one completes
        if (start_word) begin
            state_d   = S_CLEAR;
            idx_d     = '0;
            cap_d     = '0;
            clr_cnt_d = '0;
`ifdef PUF_TIMEOUT_EN
            err_d     = 1'b0;
`endif
        end
    end

    // Outputs
    always_comb begin
        bus.round_clr = (state_q == S_CLEAR);
        bus.busy      = (state_q == S_CLEAR) || (state_q == S_WAIT);
        bus.ready     = (state_q == S_HOLD);
        bus.round_idx = idx_q;
        bus.response  = resp_q;
`ifdef PUF_TIMEOUT_EN
        bus.timeout_err = (state_q == S_HOLD) && err_q;
`else
        bus.timeout_err = 1'b0;
`endif
    end
endmodule
